// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

   // Serialiser states; PARITY is only reachable when parity is built in.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // Register offsets within the 8-byte window (only bit 2 is decoded).
   localparam logic [2:0] TXDATA_OFS = 3'd0;
   localparam logic [2:0] STATUS_OFS = 3'd4;

   // STATUS register bit positions.
   localparam int STS_FULL  = 0;
   localparam int STS_EMPTY = 1;
   localparam int STS_BUSY  = 2;
   localparam int STS_OVF   = 3;
   localparam int STS_PAR   = 4;

   // Even parity over one data byte: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with combinational head-of-queue output.
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == {(AW+1){1'b0}});
   assign count     = count_q;
   assign dout      = mem_q[rd_ptr_q];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Next pointer and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + (AW+1)'(1'b1);
         2'b01:   count_d = count_q - (AW+1)'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; cleared on reset so no stale data is ever observable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA at BASE_ADDR+0, STATUS at BASE_ADDR+4.
// Frames are 8N1 by default; defining UART_TX_PARITY_EN adds an even-parity bit (8E1).
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] wd,
   output logic        sel,
   output logic [31:0] rd,
   output logic        txd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   uart_state_t   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          txd_q, txd_d;
   logic          ovf_q;

   logic          is_status_s, is_txdata_s;
   logic          wr_tx_s, wr_sts_s, push_s, pop_s, bit_end_s;
   logic [7:0]    fifo_dout_s;
   logic [CW-1:0] fifo_count_s;
   logic          fifo_full_s, fifo_empty_s;
   logic [31:0]   status_s;
   logic          unused_s;

   // Bus decode: the whole 8-byte window selects, adr[2] picks the register.
   assign sel         = (adr[31:3] == BASE_ADDR[31:3]);
   assign is_status_s = (adr[2] == STATUS_OFS[2]);
   assign is_txdata_s = (adr[2] == TXDATA_OFS[2]);
   assign wr_tx_s     = we & sel & is_txdata_s;
   assign wr_sts_s    = we & sel & is_status_s;
   // Full is judged on the pre-edge count, so a pop in the same cycle does not make room.
   assign push_s      = wr_tx_s & ~fifo_full_s;
   assign bit_end_s   = (baud_q == BAUD_LAST);
   assign txd         = txd_q;

`ifdef UART_TX_PARITY_EN
   assign unused_s = ^{adr[1:0], wd[31:8]};
`else
   assign unused_s = ^{adr[1:0], wd[31:8], par_q};
`endif

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (wd[7:0]),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // STATUS word assembly.
   always_comb begin
      status_s            = 32'h0000_0000;
      status_s[15:8]      = 8'(fifo_count_s);
      status_s[STS_PAR]   = PAR_EN;
      status_s[STS_OVF]   = ovf_q;
      status_s[STS_BUSY]  = (state_q != IDLE);
      status_s[STS_EMPTY] = fifo_empty_s;
      status_s[STS_FULL]  = fifo_full_s;
   end

   // Read mux: only STATUS returns data, everything else reads zero.
   always_comb begin
      if (sel && is_status_s) begin
         rd = status_s;
      end else begin
         rd = 32'h0000_0000;
      end
   end

   // Sticky overflow flag: set on a dropped byte, cleared by any STATUS write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else if (wr_sts_s) begin
         ovf_q <= 1'b0;
      end else if (wr_tx_s && fifo_full_s) begin
         ovf_q <= 1'b1;
      end else begin
         ovf_q <= ovf_q;
      end
   end

   // Serialiser next state; txd_d is the line level for the bit period that starts next edge.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      txd_d   = txd_q;
      pop_s   = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = {BW{1'b0}};
            bit_d  = 3'd0;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_d = fifo_dout_s;
               par_d   = even_parity(fifo_dout_s);
               state_d = START;
               txd_d   = 1'b0;
            end else begin
               txd_d   = 1'b1;
            end
         end
         START: begin
            if (bit_end_s) begin
               baud_d  = {BW{1'b0}};
               bit_d   = 3'd0;
               state_d = DATA;
               txd_d   = shift_q[0];
            end else begin
               baud_d  = baud_q + BW'(1'b1);
            end
         end
         DATA: begin
            if (bit_end_s) begin
               baud_d = {BW{1'b0}};
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  txd_d   = par_q;
`else
                  state_d = STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BW'(1'b1);
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end_s) begin
               baud_d  = {BW{1'b0}};
               state_d = STOP;
               txd_d   = 1'b1;
            end else begin
               baud_d  = baud_q + BW'(1'b1);
            end
         end
`endif
         STOP: begin
            if (bit_end_s) begin
               baud_d = {BW{1'b0}};
               bit_d  = 3'd0;
               if (!fifo_empty_s) begin
                  // Back-to-back frame: no idle bit between stop and next start.
                  pop_s   = 1'b1;
                  shift_d = fifo_dout_s;
                  par_d   = even_parity(fifo_dout_s);
                  state_d = START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end else begin
               baud_d = baud_q + BW'(1'b1);
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = {BW{1'b0}};
            bit_d   = 3'd0;
            txd_d   = 1'b1;
         end
      endcase
   end

   // Serialiser registers; reset forces the line high immediately, aborting any frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= {BW{1'b0}};
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x200).
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int   NBITS = 11;
   localparam logic PAR   = 1'b1;
`else
   localparam int   NBITS = 10;
   localparam logic PAR   = 1'b0;
`endif
   localparam int FL = NBITS * CPB;
   localparam logic [31:0] BASE = 32'h0000_0200;
   localparam logic [31:0] IDLE_STS = {27'b0, PAR, 4'b0010};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic [31:0] adr = 32'h0000_0060;
   logic [31:0] wd = 32'h0;
   logic        sel;
   logic [31:0] rd;
   logic        txd;

   int vectors = 0;
   int miscompares = 0;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .adr   (adr),
      .wd    (wd),
      .sel   (sel),
      .rd    (rd),
      .txd   (txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // ---------------- reference model (time-based) ----------------
   // Bytes waiting in the FIFO, bytes expected on the line, and the cycle at which
   // the current frame's stop bit ends (the line is free again from then on).
   logic [7:0] fifo_m[$];
   logic [7:0] exp_q[$];
   int cyc;
   int frame_end;
   bit ovf_m;
   int pre_m;
   logic [7:0] drop_m;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_m.delete();
         exp_q.delete();
         cyc = 0;
         frame_end = 0;
         ovf_m = 1'b0;
      end else begin
         cyc++;
         pre_m = fifo_m.size();
         if (pre_m > 0 && cyc >= frame_end) begin
            drop_m = fifo_m.pop_front();
            frame_end = cyc + FL;
         end
         if (we && (adr[31:3] == BASE[31:3])) begin
            if (!adr[2]) begin
               if (pre_m < DEPTH) begin
                  fifo_m.push_back(wd[7:0]);
                  exp_q.push_back(wd[7:0]);
               end else begin
                  ovf_m = 1'b1;
               end
            end else begin
               ovf_m = 1'b0;
            end
         end
      end
   end

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      int n;
      n = fifo_m.size();
      s = 32'h0;
      s[15:8] = n[7:0];
      s[4] = PAR;
      s[3] = ovf_m;
      s[2] = (cyc < frame_end);
      s[1] = (n == 0);
      s[0] = (n == DEPTH);
      return s;
   endfunction

   // ---------------- line monitor ----------------
   bit mon_act = 1'b0;
   int mon_t;
   int mon_idx;
   logic [7:0] mon_byte;
   int ncyc = 0;
   int frames = 0;
   int start_c[$];

   always @(negedge clk) begin
      ncyc++;
      if (!reset) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (txd === 1'b0) begin
            mon_act = 1'b1;
            mon_t = 0;
            start_c.push_back(ncyc);
         end
      end else begin
         mon_t++;
         if (mon_t % CPB == 1) begin
            mon_idx = (mon_t - 1) / CPB;
            if (mon_idx == 0) begin
               check("start_bit", 32'(txd), 32'h0);
            end else if (mon_idx <= 8) begin
               mon_byte[mon_idx-1] = txd;
            end else if (PAR && mon_idx == 9) begin
               check("parity_bit", 32'(txd), 32'(^mon_byte));
            end else begin
               check("stop_bit", 32'(txd), 32'h1);
               frames++;
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_frame: got 0x%02h expected no frame", mon_byte);
               end else begin
                  check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
               end
               mon_act = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      we = 1'b1;
      adr = a;
      wd = d;
      @(negedge clk);
      we = 1'b0;
      adr = 32'h0000_0060;
   endtask

   task automatic rd_status(input string name);
      adr = BASE + 32'h4;
      #1;
      check(name, rd, exp_status());
   endtask

   task automatic idle_wait();
      int n;
      n = 0;
      while ((fifo_m.size() != 0 || cyc < frame_end || mon_act) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
      end
      check("frames_drained", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic check_gaps(input int s0, input int nfr);
      for (int i = 1; i < nfr; i++) begin
         if (s0 + i < start_c.size()) begin
            check("frame_gap", 32'(start_c[s0+i] - start_c[s0+i-1]), 32'(FL));
         end else begin
            check("frame_gap_missing", 32'(start_c.size()), 32'(s0 + i + 1));
         end
      end
   endtask

   int f0, s0;
   logic [31:0] a;

   initial begin
      // 1: reset state
      do_reset();
      check("reset_txd", 32'(txd), 32'h1);
      rd_status("reset_status");
      check("reset_status_const", rd, IDLE_STS);
      adr = 32'h0000_0060;
      #1;
      check("sel_ram", 32'(sel), 32'h0);
      check("rd_ram", rd, 32'h0);
      adr = BASE + 32'h4;
      #1;
      check("sel_status", 32'(sel), 32'h1);
      @(negedge clk);

      // 2: single frame 0x55
      f0 = frames;
      wr(BASE, 32'hFFFF_FF55);
      repeat (5) @(negedge clk);
      rd_status("t2_busy");
      check("t2_busy_bit", 32'(rd[2]), 32'h1);
      idle_wait();
      rd_status("t2_idle");
      check("t2_idle_const", rd, IDLE_STS);
      check("t2_frames", 32'(frames - f0), 32'h1);

      // 3: five back-to-back writes, continuous frames
      f0 = frames;
      s0 = start_c.size();
      for (int i = 0; i < 5; i++) wr(BASE, 32'h41 + 32'(i));
      rd_status("t3_status");
      check("t3_count", 32'(rd[15:8]), 32'h4);
      check("t3_full", 32'(rd[0]), 32'h1);
      idle_wait();
      check("t3_frames", 32'(frames - f0), 32'h5);
      check_gaps(s0, 5);

      // 4: overflow then clear
      f0 = frames;
      for (int i = 0; i < 6; i++) wr(BASE | 32'($urandom_range(0, 3)), 32'($urandom_range(0, 255)));
      rd_status("t4_status");
      check("t4_ovf", 32'(rd[3]), 32'h1);
      wr(BASE + 32'h4, 32'hFFFF_FFFF);
      rd_status("t4_cleared");
      check("t4_ovf_clear", 32'(rd[3]), 32'h0);
      idle_wait();
      check("t4_frames", 32'(frames - f0), 32'h5);

      // 5: reset during data bit 3 of 0x0F
      wr(BASE, 32'h0F);
      repeat (18) @(negedge clk);
      #1 reset = 1'b0;
      #1 check("t5_txd_async", 32'(txd), 32'h1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      f0 = frames;
      rd_status("t5_status");
      check("t5_status_const", rd, IDLE_STS);
      repeat (60) @(negedge clk);
      check("t5_no_frame", 32'(frames - f0), 32'h0);
      check("t5_txd_idle", 32'(txd), 32'h1);

      // 5b: reset while the start bit drives the line low
      wr(BASE, 32'h00);
      repeat (2) @(negedge clk);
      check("t5b_start_low", 32'(txd), 32'h0);
      #1 reset = 1'b0;
      #1 check("t5b_txd_async", 32'(txd), 32'h1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

`ifdef UART_TX_PARITY_EN
      // 6: parity frame length and STATUS[4]
      s0 = start_c.size();
      wr(BASE, 32'h07);
      wr(BASE, 32'h07);
      rd_status("t6_status");
      check("t6_par_bit", 32'(rd[4]), 32'h1);
      idle_wait();
      check_gaps(s0, 2);
`endif

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         int op;
         repeat ($urandom_range(0, 50)) @(negedge clk);
         op = $urandom_range(0, 9);
         if (op <= 6) begin
            wr(BASE | 32'($urandom_range(0, 3)), $urandom);
         end else if (op == 7) begin
            wr(BASE + 32'h4 + 32'($urandom_range(0, 3)), $urandom);
         end else if (op == 8) begin
            rd_status("rand_status");
         end else begin
            a = $urandom;
            if (a[31:3] == BASE[31:3]) a = a ^ 32'h8000_0000;
            adr = a;
            #1;
            check("rand_sel_off", 32'(sel), 32'h0);
            check("rand_rd_off", rd, 32'h0);
            @(negedge clk);
            wr(a & 32'hFFFF_FFF8, $urandom);
         end
      end
      idle_wait();
      rd_status("final_status");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
